fir_out_conditioner: RTL and testbench

- Downstream stage of the direct-form filter: consumes the filter's full-precision integer output every clock.
- Removes filter gain by rounding right-shift, saturates to a narrow output word, and decimates by DECIM.
- Buffers results in a small FIFO behind a valid/ready handshake for the next consumer (DAC model / logger).
- Sticky status flags report saturation and FIFO overflow.

---
 rtl/fir_cond_pkg.sv | 46 ++++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/fir_out_conditioner.sv | 95 +++++++++
 tb/tb_fir_out_conditioner.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_cond_pkg.sv
// Shared arithmetic helpers for the filter output conditioner:
// rounding right-shift and saturation on a wide signed carrier.
package fir_cond_pkg;

    localparam int OUT_W_DEF = 16;
    localparam int OUT_MAX   = 2 ** (OUT_W_DEF - 1) - 1;
    localparam int OUT_MIN   = -(2 ** (OUT_W_DEF - 1));

    // 64-bit carrier leaves headroom so the rounding add never wraps
    function automatic logic signed [63:0] round_shift(
        input logic signed [63:0] x,
        input int                 sh
    );
        logic signed [63:0] bias;
        bias = 64'sd0;
        if (sh > 0) bias = 64'sd1 <<< (sh - 1);
        return (x + bias) >>> sh;
    endfunction

    function automatic logic signed [63:0] lim_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] lim_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic clamps(
        input logic signed [63:0] x,
        input int                 w
    );
        return (x > lim_max(w)) || (x < lim_min(w));
    endfunction

    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] x,
        input int                 w
    );
        logic signed [63:0] y;
        y = x;
        if (x > lim_max(w)) y = lim_max(w);
        if (x < lim_min(w)) y = lim_min(w);
        return y;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word and exact occupancy.
// Push while full is accepted only when a pop frees a slot the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign fill    = count;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // head register follows the next oldest entry
            if (do_pop) begin
                if (count > (AW+1)'(1)) dout <= mem[rd_ptr + AW'(1)];
                else if (do_push)       dout <= din;
            end else if (empty && do_push) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/fir_out_conditioner.sv
// Filter output conditioner: decimate, round/shift, saturate, then buffer
// behind a valid/ready FIFO with sticky saturation and overflow flags.
module fir_out_conditioner
    import fir_cond_pkg::*;
#(
    parameter int IN_W       = 32,
    parameter int OUT_W      = 16,
    parameter int SHIFT      = 3,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic signed [IN_W-1:0]          din,
    input  logic                            din_valid,
    output logic signed [OUT_W-1:0]         dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fill,
    output logic                            sat_flag,
    output logic                            ovf_flag
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DW-1:0]           dcnt;
    logic                    keep;
    logic                    s1_valid;
    logic signed [IN_W:0]    s1_r;
    logic                    s2_valid;
    logic signed [OUT_W-1:0] s2_d;
    logic                    pq_valid;
    logic signed [OUT_W-1:0] pq_d;
    logic signed [63:0]      r_full;
    logic signed [63:0]      s1_ext;
    logic signed [63:0]      sat_v;
    logic                    s1_clamp;
    logic [OUT_W-1:0]        f_dout;
    logic                    f_empty;
    logic                    f_full;

    assign keep = din_valid && (dcnt == '0);

    always_comb begin
        r_full   = round_shift(64'(din), SHIFT);
        s1_ext   = 64'(s1_r);
        sat_v    = saturate(s1_ext, OUT_W);
        s1_clamp = clamps(s1_ext, OUT_W);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dcnt     <= '0;
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s2_valid <= 1'b0;
            s2_d     <= '0;
            pq_valid <= 1'b0;
            pq_d     <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            if (din_valid)
                dcnt <= (dcnt == DW'(DECIM - 1)) ? '0 : dcnt + DW'(1);
            s1_valid <= keep;
            if (keep) s1_r <= r_full[IN_W:0];
            s2_valid <= s1_valid;
            if (s1_valid) s2_d <= sat_v[OUT_W-1:0];
            if (s1_valid && s1_clamp) sat_flag <= 1'b1;
            pq_valid <= s2_valid;
            if (s2_valid) pq_d <= s2_d;
            // full FIFO without a pop this cycle drops the sample
            if (pq_valid && f_full && !dout_ready) ovf_flag <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pq_valid),
        .din   (pq_d),
        .pop   (dout_ready),
        .dout  (f_dout),
        .empty (f_empty),
        .full  (f_full),
        .fill  (fill)
    );

    assign dout       = signed'(f_dout);
    assign dout_valid = !f_empty;

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Directed bench for fir_out_conditioner at default parameters
// (SHIFT=3, DECIM=2, OUT_W=16, FIFO_DEPTH=4).
module tb_fir_out_conditioner;

    import fir_cond_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] din;
    logic               din_valid;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               dout_ready;
    logic [2:0]         fill;
    logic               sat_flag;
    logic               ovf_flag;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int din;
        bit vld;
        bit rdy;
        bit ev;
        int ed;
        int ef;
        bit es;
    } vec_t;

    vec_t tv[$];

    always #5 clk = ~clk;

    fir_out_conditioner #(
        .IN_W       (32),
        .OUT_W      (16),
        .SHIFT      (3),
        .DECIM      (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fill       (fill),
        .sat_flag   (sat_flag),
        .ovf_flag   (ovf_flag)
    );

    function automatic vec_t mk(int d, bit v, bit r, bit ev, int ed, int ef, bit es);
        vec_t t;
        t.din = d; t.vld = v; t.rdy = r;
        t.ev = ev; t.ed = ed; t.ef = ef; t.es = es;
        return t;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int d, bit v, bit r);
        din        = d;
        din_valid  = v;
        dout_ready = r;
    endtask

    task automatic chk_state(string tag, bit ev, int ed, int ef, bit es, bit eo);
        chk({tag, " dout_valid"}, int'(dout_valid), int'(ev));
        if (ev) chk({tag, " dout"}, int'(dout), ed);
        chk({tag, " fill"}, int'(fill), ef);
        chk({tag, " sat_flag"}, int'(sat_flag), int'(es));
        chk({tag, " ovf_flag"}, int'(ovf_flag), int'(eo));
    endtask

    initial begin
        int exp4 [4];
        int next_exp;
        bit found;

        // rounding, latency and saturation vectors (ovf stays 0)
        tv.push_back(mk(7,       1, 1, 0, 0,      0, 0));
        tv.push_back(mk(99,      1, 1, 0, 0,      0, 0));
        tv.push_back(mk(-5,      1, 1, 0, 0,      0, 0));
        tv.push_back(mk(99,      1, 1, 1, 1,      1, 0));
        tv.push_back(mk(12,      1, 1, 0, 0,      0, 0));
        tv.push_back(mk(99,      1, 1, 1, -1,     1, 0));
        tv.push_back(mk(0,       0, 1, 0, 0,      0, 0));
        tv.push_back(mk(0,       0, 1, 1, 2,      1, 0));
        tv.push_back(mk(0,       0, 1, 0, 0,      0, 0));
        tv.push_back(mk(400000,  1, 1, 0, 0,      0, 0));
        tv.push_back(mk(0,       1, 1, 0, 0,      0, 1));
        tv.push_back(mk(-400000, 1, 1, 0, 0,      0, 1));
        tv.push_back(mk(0,       1, 1, 1, OUT_MAX, 1, 1));
        tv.push_back(mk(8,       1, 1, 0, 0,      0, 1));
        tv.push_back(mk(0,       1, 1, 1, OUT_MIN, 1, 1));
        tv.push_back(mk(0,       0, 1, 0, 0,      0, 1));
        tv.push_back(mk(0,       0, 1, 1, 1,      1, 1));
        tv.push_back(mk(0,       0, 1, 0, 0,      0, 1));
        tv.push_back(mk(-4,      1, 1, 0, 0,      0, 1));
        tv.push_back(mk(0,       1, 1, 0, 0,      0, 1));
        tv.push_back(mk(-12,     1, 1, 0, 0,      0, 1));
        tv.push_back(mk(0,       1, 1, 1, 0,      1, 1));
        tv.push_back(mk(0,       0, 1, 0, 0,      0, 1));
        tv.push_back(mk(0,       0, 1, 1, -1,     1, 1));
        tv.push_back(mk(0,       0, 1, 0, 0,      0, 1));

        // reset held with random traffic
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(int'($urandom), 1'b1, 1'(($urandom & 1)));
            tick();
            chk($sformatf("reset[%0d] dout", i), int'(dout), 0);
            chk_state($sformatf("reset[%0d]", i), 1'b0, 0, 0, 1'b0, 1'b0);
        end
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].din, tv[i].vld, tv[i].rdy);
            tick();
            chk_state($sformatf("vec[%0d]", i), tv[i].ev, tv[i].ed,
                      tv[i].ef, tv[i].es, 1'b0);
        end

        // backpressure and overflow
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        for (int v = 0; v < 20; v++) begin
            drive(v, 1'b1, 1'b0);
            tick();
        end
        drive(0, 1'b0, 1'b0);
        repeat (4) tick();
        chk_state("ovf full", 1'b1, 0, 4, 1'b0, 1'b1);
        exp4 = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 1'b1);
            chk($sformatf("drain[%0d] dout_valid", i), int'(dout_valid), 1);
            chk($sformatf("drain[%0d] dout", i), int'(dout), exp4[i]);
            tick();
        end
        chk_state("drained", 1'b0, 0, 0, 1'b0, 1'b1);

        // simultaneous push and pop while full
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        next_exp = 0;
        for (int v = 0; v < 24; v++) begin
            drive((v % 2 == 0) ? 8 * (v / 2) : 999, 1'b1,
                  (v >= 11) && (v % 2 == 1));
            if (dout_ready && dout_valid) begin
                chk($sformatf("pp order %0d", next_exp), int'(dout), next_exp);
                next_exp++;
            end
            tick();
            if (v >= 9) chk($sformatf("pp fill[%0d]", v), int'(fill), 4);
        end
        for (int i = 0; i < 12; i++) begin
            drive(0, 1'b0, 1'b1);
            if (dout_valid) begin
                chk($sformatf("pp order %0d", next_exp), int'(dout), next_exp);
                next_exp++;
            end
            tick();
        end
        chk("pp delivered", next_exp, 12);
        chk_state("pp end", 1'b0, 0, 0, 1'b0, 1'b0);

        // reset mid-stream with three entries buffered
        reset = 1'b1;
        drive(0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(400000, 1'b1, 1'b0);
            tick();
            if (fill == 3) found = 1'b1;
        end
        chk("mid fill reached 3", int'(found), 1);
        reset = 1'b1;
        drive(400000, 1'b1, 1'b0);
        tick();
        reset = 1'b0;
        chk_state("mid reset", 1'b0, 0, 0, 1'b0, 1'b0);
        drive(80, 1'b1, 1'b1);
        tick();
        chk("post a fill", int'(fill), 0);
        drive(400000, 1'b1, 1'b1);
        tick();
        chk("post b fill", int'(fill), 0);
        drive(0, 1'b0, 1'b0);
        tick();
        chk("post c dout_valid", int'(dout_valid), 0);
        tick();
        chk_state("post first", 1'b1, 10, 1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
